instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL take parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL size every address and data path by WORD_WIDTH (16) from parameters.v; no local override.
REQ-003 SHALL have clk input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have mem_req output, 1 bit: instruction memory read request.
REQ-006 SHALL have mem_addr output, WORD_WIDTH: word address of the outstanding request.
REQ-007 SHALL have mem_ack input, 1 bit: read complete; mem_rdata is valid in the same cycle.
REQ-008 SHALL have mem_rdata input, WORD_WIDTH: fetched instruction word.
REQ-009 SHALL have instr output, WORD_WIDTH: instruction word presented to instr_decode.
REQ-010 SHALL have instr_pc output, WORD_WIDTH: address that instr was fetched from.
REQ-011 SHALL have instr_valid output, 1 bit: instr and instr_pc are valid.
REQ-012 SHALL have instr_ready input, 1 bit: consumer accepts; a transfer occurs when instr_valid and instr_ready are both high.
REQ-013 SHALL have redirect input, 1 bit: branch or jump; flushes the fetch stream.
REQ-014 SHALL have redirect_pc input, WORD_WIDTH: new fetch address, sampled when redirect is high.

Function
REQ-015 SHALL hold fetch PC; word-addressed; increments by 1 per issued request; 16'hFFFF wraps to 16'h0000.
REQ-016 SHALL implement a three-state FSM: IDLE (no request), WAIT (request outstanding), DROP (stale request outstanding, its data to be discarded).
REQ-017 SHALL assert mem_req in WAIT and DROP and keep mem_addr stable until mem_ack; at most one request outstanding.
REQ-018 SHALL go IDLE->WAIT and present mem_req in the same cycle when buffer occupancy, after any same-cycle pop, is below depth.
REQ-019 SHALL, on mem_ack in WAIT, push {mem_rdata, mem_addr} into the buffer; next state WAIT (back-to-back, next PC) if space remains, else IDLE.
REQ-020 SHALL, on mem_ack in DROP, discard data and go to WAIT at the redirected PC.
REQ-021 SHALL drive instr/instr_pc/instr_valid from the buffer head; data is registered, so mem_ack to instr_valid latency is 1 cycle.
REQ-022 SHALL keep instr and instr_pc stable while instr_valid is high and instr_ready is low.
REQ-023 SHALL, on redirect, flush the buffer (instr_valid low next cycle) and load PC from redirect_pc; redirect overrides any same-cycle pop or push.
REQ-024 SHALL, on redirect in WAIT without same-cycle mem_ack, go to DROP; with same-cycle mem_ack, discard the data and go to WAIT at redirect_pc.
REQ-025 SHALL, on redirect in IDLE, go to WAIT at redirect_pc on the next cycle.
REQ-026 SHALL, on redirect in DROP, update the target PC and remain in DROP.
REQ-027 SHALL allow a push and a pop in the same cycle with occupancy unchanged.

Reset
REQ-028 SHALL, while rst_n is low, force IDLE, PC=RESET_PC, empty buffer, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-029 SHALL drop any in-flight request on reset, with no DROP carried over; mem_ack during reset is ignored.
REQ-030 SHALL assert mem_req in the first clock edge cycle after rst_n rises.

Configuration
REQ-031 SHALL, with FETCH_PREFETCH_EN defined, use a 2-entry buffer; a request may be outstanding while one entry waits unconsumed.
REQ-032 SHALL, without FETCH_PREFETCH_EN, use a 1-entry buffer and issue no request while the entry is occupied and not being popped.

Verification
REQ-033 SHALL cover: reset release, RESET_PC=0, ack every cycle, ready=1 -> mem_addr 0,1,2,3 on consecutive cycles; instr_pc 0,1,2 one cycle after each ack.
REQ-034 SHALL cover: ready=0 after reset, ack immediate -> with macro, 2 entries (pc 0,1) held and mem_req low; without macro, 1 entry (pc 0), mem_req low.
REQ-035 SHALL cover: redirect to 16'h0040 while WAIT at addr 5, ack 3 cycles later -> DROP, data 5 never on instr, next mem_addr 16'h0040.
REQ-036 SHALL cover: redirect to 16'h0010 in the same cycle as ack of addr 7 -> addr 7 discarded, buffer empty, mem_addr 16'h0010 next cycle.
REQ-037 SHALL cover: redirect_pc 16'hFFFF, ack every cycle -> mem_addr 16'hFFFF then 16'h0000.
REQ-038 SHALL cover: rst_n low mid-WAIT for 1 cycle, then mem_ack -> ack ignored, restart at RESET_PC, instr_valid 0.

Source files
------------

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. It reads instruction words from memory with a
// single-outstanding req/ack handshake and queues them, tagged with their
// address, in a small buffer. The buffer head is handed to instr_decode
// through a valid/ready handshake. A redirect (branch or jump) flushes the
// buffer and restarts fetching at redirect_pc. If a request is still in
// flight when the redirect arrives, that request's data is thrown away.
//
// Ports
//   clk          in   single clock; all state changes on its rising edge
//   rst_n        in   asynchronous, active-low reset
//   mem_req      out  instruction memory read request
//   mem_addr     out  word address of the outstanding request
//   mem_ack      in   read complete; mem_rdata is valid in the same cycle
//   mem_rdata    in   fetched instruction word
//   instr        out  instruction word presented to instr_decode
//   instr_pc     out  address that instr was fetched from
//   instr_valid  out  instr and instr_pc are valid
//   instr_ready  in   consumer accepts; transfer when valid && ready
//   redirect     in   branch or jump; flushes the fetch stream
//   redirect_pc  in   new fetch address, sampled when redirect is high
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Configuration macro
//   FETCH_PREFETCH_EN  defined  : 2-entry buffer. A request may be in
//                                 flight while one entry is still waiting
//                                 to be consumed.
//                      undefined: 1-entry buffer. No request is issued while
//                                 that entry is occupied and not being popped.
//
// The word width comes from the project-wide `WORD_WIDTH (parameters.v). The
// fallback definition below is used only when that file is not compiled
// first.
// ----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request outstanding (a request may be raised combinationally)
// WAIT  | request outstanding at pc_q; its data is pushed on mem_ack
// DROP  | stale request outstanding at pc_q; data discarded, then refetch
//       | from tgt_q
module instr_fetch #(
    parameter logic [`WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [`WORD_WIDTH-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [`WORD_WIDTH-1:0] mem_rdata,
    output logic [`WORD_WIDTH-1:0] instr,
    output logic [`WORD_WIDTH-1:0] instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   redirect,
    input  logic [`WORD_WIDTH-1:0] redirect_pc
);

    localparam int W = `WORD_WIDTH;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] pc_q, pc_d;     // address of the outstanding/next request
    logic [W-1:0] tgt_q, tgt_d;   // refetch address while in DROP
    logic [1:0]   cnt_q, cnt_d;   // buffer occupancy

    // Shift-style buffer: entry 0 is always the head, so the outputs come
    // straight from flops.
    logic [W-1:0] buf_data_q [DEPTH];
    logic [W-1:0] buf_data_d [DEPTH];
    logic [W-1:0] buf_pc_q   [DEPTH];
    logic [W-1:0] buf_pc_d   [DEPTH];

    logic       pop;
    logic       push;
    logic       issue_idle;
    logic       req;
    logic       ack;
    logic [1:0] occ_after_pop;
    logic [1:0] occ_after_push;

    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = buf_data_q[0];
    assign instr_pc    = buf_pc_q[0];

    assign pop            = instr_valid & instr_ready;
    assign occ_after_pop  = cnt_q - {1'b0, pop};
    assign occ_after_push = occ_after_pop + 2'd1;

    // IDLE raises the request in the same cycle it finds room. A redirect
    // holds it off, because the fetch address is about to change.
    assign issue_idle = (state_q == S_IDLE) && (occ_after_pop < DEPTH_C) && !redirect;
    assign req        = (state_q == S_WAIT) || (state_q == S_DROP) || issue_idle;
    assign ack        = mem_ack & req;

    // Gating with rst_n keeps the request low for the whole reset, including
    // before the first clock edge has loaded the flops.
    assign mem_req  = rst_n & req;
    assign mem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        push    = 1'b0;

        if (redirect) begin
            if ((state_q == S_WAIT || state_q == S_DROP) && !ack) begin
                // The old request must complete at its current address.
                state_d = S_DROP;
                tgt_d   = redirect_pc;
            end else begin
                // Either nothing is in flight or it completes right now and
                // its data is discarded.
                state_d = S_WAIT;
                pc_d    = redirect_pc;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_idle) begin
                        if (ack) begin
                            push    = 1'b1;
                            pc_d    = pc_q + 1'b1;
                            state_d = (occ_after_push < DEPTH_C) ? S_WAIT : S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + 1'b1;
                        state_d = (occ_after_push < DEPTH_C) ? S_WAIT : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        state_d = S_WAIT;
                        pc_d    = tgt_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // WAIT is only ever entered with room left in the buffer, so a push
    // always has a free slot at index occ_after_pop.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                buf_data_d[i] = buf_data_q[i+1];
                buf_pc_d[i]   = buf_pc_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (2'(i) == occ_after_pop) begin
                    buf_data_d[i] = mem_rdata;
                    buf_pc_d[i]   = pc_q;
                end
            end
        end
    end

    // A redirect flushes the buffer. Only the count needs clearing; stale
    // entry contents are never visible while instr_valid is low.
    assign cnt_d = redirect ? 2'd0 : (occ_after_pop + {1'b0, push});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            cnt_q   <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_pc_q[i]   <= buf_pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. The reference model keeps the fetch
// stream as a queue of {data, pc} entries, plus flags for a live request
// and a stale (to-be-discarded) request. Memory data is a fixed hash of the
// address. Directed sequences cover the reset and redirect corner cases;
// these are followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_pc;          // next fetch address (refetch target when stale)
    logic [15:0] m_stale_addr;
    bit          m_busy;
    bit          m_stale;

    int n_checks = 0;
    int n_errors = 0;

    logic        obs_req;
    logic [15:0] obs_addr;
    logic        obs_valid;
    logic [15:0] obs_pc;
    bit          saw5;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Entered with clk low. Holds reset across exactly one rising edge,
    // with mem_ack high to show that it is ignored.
    task automatic do_reset();
        rst_n       = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hDEAD;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        q.delete();
        m_pc    = RST_PC;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_mem_req", int'(mem_req), 0);
        check_val("rst_mem_addr", int'(mem_addr), int'(RST_PC));
        check_val("rst_valid", int'(instr_valid), 0);
        check_val("rst_instr", int'(instr), 0);
        check_val("rst_instr_pc", int'(instr_pc), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model,
    // then advance the model across the rising edge. Entered and left at the
    // falling edge.
    task automatic step(input logic rdy, input logic rd, input logic [15:0] rpc,
                        input logic want_ack);
        bit          pop;
        bit          req;
        bit          ack;
        int          occ;
        logic [15:0] a;
        ent_t        e;

        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        pop = (q.size() > 0) && rdy;
        occ = q.size() - (pop ? 1 : 0);
        req = m_busy || m_stale || ((occ < DEPTH) && !rd);
        a   = m_stale ? m_stale_addr : m_pc;
        ack = want_ack && req;
        mem_ack = ack;
        #1;
        mem_rdata = mem_fn(mem_addr);
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        if (instr_valid && instr_pc == 16'h0005) saw5 = 1'b1;

        check_val("mem_req", int'(mem_req), int'(req));
        if (req) check_val("mem_addr", int'(mem_addr), int'(a));
        check_val("instr_valid", int'(instr_valid), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) begin
            check_val("instr", int'(instr), int'(q[0].data));
            check_val("instr_pc", int'(instr_pc), int'(q[0].pc));
        end

        @(posedge clk);
        if (rd) begin
            q.delete();
            if ((m_busy || m_stale) && !ack) begin
                m_stale      = 1'b1;
                m_stale_addr = a;
                m_busy       = 1'b0;
            end else begin
                m_stale = 1'b0;
                m_busy  = 1'b1;
            end
            m_pc = rpc;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_stale) begin
                if (ack) begin
                    m_stale = 1'b0;
                    m_busy  = 1'b1;
                end
            end else if (req) begin
                if (ack) begin
                    e.data = mem_fn(a);
                    e.pc   = a;
                    q.push_back(e);
                    m_pc   = a + 16'd1;
                    m_busy = (q.size() < DEPTH);
                end else begin
                    m_busy = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        saw5        = 1'b0;
        #1;

        // Streaming from reset with an ack every cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1);
            check_val("s1_addr", int'(obs_addr), k);
            check_val("s1_req", int'(obs_req), 1);
            if (k > 0) check_val("s1_pc", int'(obs_pc), k - 1);
        end

        // Consumer stalled: the buffer fills and requests stop
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        check_val("s2_req", int'(obs_req), 0);
        check_val("s2_valid", int'(obs_valid), 1);
        check_val("s2_pc", int'(obs_pc), 0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s2_pop_pc", int'(obs_pc), 0);
`ifdef FETCH_PREFETCH_EN
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("s2_second_pc", int'(obs_pc), 1);
        check_val("s2_second_valid", int'(obs_valid), 1);
`endif

        // Redirect while waiting; the ack arrives three cycles later
        do_reset();
        saw5 = 1'b0;
        step(1'b1, 1'b1, 16'h0005, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s3_wait_addr", int'(obs_addr), 5);
        step(1'b1, 1'b1, 16'h0040, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s3_drop_addr", int'(obs_addr), 5);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check_val("s3_new_addr", int'(obs_addr), 16'h0040);
        check_val("s3_valid", int'(obs_valid), 0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s3_first_pc", int'(obs_pc), 16'h0040);
        check_val("s3_no_addr5", int'(saw5), 0);

        // Redirect in the same cycle as an ack
        do_reset();
        step(1'b1, 1'b1, 16'h0007, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s4_wait_addr", int'(obs_addr), 7);
        step(1'b1, 1'b1, 16'h0010, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_val("s4_new_addr", int'(obs_addr), 16'h0010);
        check_val("s4_valid", int'(obs_valid), 0);

        // Address wrap at the top of memory
        do_reset();
        step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check_val("s5_addr_ffff", int'(obs_addr), 16'hFFFF);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        check_val("s5_addr_0000", int'(obs_addr), 16'h0000);
        check_val("s5_pc_ffff", int'(obs_pc), 16'hFFFF);

        // Reset in the middle of a wait; the ack during reset is ignored
        do_reset();
        step(1'b0, 1'b1, 16'h0123, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("s6_wait_addr", int'(obs_addr), 16'h0123);
        do_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("s6_req", int'(obs_req), 1);
        check_val("s6_addr", int'(obs_addr), int'(RST_PC));
        check_val("s6_valid", int'(obs_valid), 0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("s6_pc", int'(obs_pc), int'(RST_PC));

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] rpc;
            rpc = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rpc = 16'hFFFE + 16'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 rpc,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
